qupls_rename_map: RTL and testbench

//  Parametrised register alias table for the Q+ rename stage with a circular checkpoint stack.

---
 rtl/qupls_rename_map.sv | 179 +++++++++++++++++
 tb/tb_qupls_rename_map.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qupls_rename_map.sv
// Register alias table for the Q+ rename stage: arch->phys map with ready bits, same-cycle
// rename bypass, and a circular stack of map checkpoints restored in one cycle on a branch miss.
module qupls_rename_map #(
    parameter int unsigned AREGS = 64,
    parameter int unsigned PREGS = 256,
    parameter int unsigned NRD   = 8,
    parameter int unsigned NWR   = 4,
    parameter int unsigned NWB   = 4,
    parameter int unsigned NCP   = 16,
    localparam int unsigned AW   = $clog2(AREGS),
    localparam int unsigned PW   = $clog2(PREGS),
    localparam int unsigned CW   = $clog2(NCP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_areg,
    output logic [NRD*PW-1:0] rd_preg,
    output logic [NRD-1:0]    rd_v,
    input  logic [NWR-1:0]    wr_v,
    input  logic [NWR*AW-1:0] wr_areg,
    input  logic [NWR*PW-1:0] wr_preg,
    output logic [NWR*PW-1:0] wr_old_preg,
    input  logic [NWB-1:0]    wb_v,
    input  logic [NWB*PW-1:0] wb_preg,
    input  logic              cp_alloc,
    output logic [CW-1:0]     cp_id,
    output logic              cp_full,
    input  logic              cp_free,
    input  logic              restore,
    input  logic [CW-1:0]     restore_cp,
    output logic [CW:0]       cp_count
);

    localparam logic [CW:0] CpFull = (CW+1)'(NCP);

    logic [PW-1:0]    map_preg_q [AREGS];
    logic [PW-1:0]    map_preg_d [AREGS];
    logic [AREGS-1:0] map_v_q, map_v_d;
    logic [PW-1:0]    ckpt_preg_q [NCP][AREGS];
    logic [AREGS-1:0] ckpt_v_q [NCP];
    logic [CW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW:0]      count_q, count_d;

    logic [AW-1:0] rd_a [NRD];
    logic [AW-1:0] wr_a [NWR];
    logic [PW-1:0] wr_p [NWR];
    logic [CW-1:0] restore_rel;
    logic          restore_ok, state_en, free_ok, alloc_ok;

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        assign rd_a[g] = rd_areg[g*AW +: AW];
    end
    for (genvar g = 0; g < NWR; g++) begin : g_wr
        assign wr_a[g] = wr_areg[g*AW +: AW];
        assign wr_p[g] = wr_preg[g*PW +: PW];
    end

    function automatic logic wb_hit(input logic [PW-1:0] p, input logic [NWB-1:0] v,
                                    input logic [NWB*PW-1:0] pr);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NWB; k++) begin
            if (v[k] && pr[k*PW +: PW] == p) hit = 1'b1;
        end
        return hit;
    endfunction

    // Restore target must lie in the live window [head, tail).
    assign restore_rel = restore_cp - head_q;
    assign restore_ok  = restore && ({1'b0, restore_rel} < count_q);
    assign state_en    = !restore || restore_ok;
    assign free_ok     = !restore && cp_free && (count_q != '0);
    // A free in the same cycle makes room, so a full stack can still take an alloc.
    assign alloc_ok    = !restore && cp_alloc && ((count_q != CpFull) || free_ok);

    assign cp_id    = tail_q;
    assign cp_count = count_q;
    assign cp_full  = (count_q == CpFull);

    always_comb begin
        for (int r = 0; r < NRD; r++) begin
            rd_preg[r*PW +: PW] = map_preg_q[rd_a[r]];
            rd_v[r]             = map_v_q[rd_a[r]];
            for (int w = 0; w < NWR; w++) begin
                if (wr_v[w] && wr_a[w] == rd_a[r]) begin
                    rd_preg[r*PW +: PW] = wr_p[w];
                    rd_v[r]             = 1'b0;
                end
            end
            if (rd_a[r] == '0) begin
                rd_preg[r*PW +: PW] = '0;
                rd_v[r]             = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NWR; i++) begin
            wr_old_preg[i*PW +: PW] = map_preg_q[wr_a[i]];
            for (int j = 0; j < NWR; j++) begin
                if (j < i && wr_v[j] && wr_a[j] == wr_a[i] && wr_a[i] != '0) begin
                    wr_old_preg[i*PW +: PW] = wr_p[j];
                end
            end
        end
    end

    always_comb begin
        map_preg_d = map_preg_q;
        map_v_d    = map_v_q;
        if (restore_ok) begin
            map_preg_d = ckpt_preg_q[restore_cp];
            map_v_d    = ckpt_v_q[restore_cp];
        end
        if (state_en) begin
            for (int a = 0; a < AREGS; a++) begin
                if (wb_hit(map_preg_d[a], wb_v, wb_preg)) map_v_d[a] = 1'b1;
            end
        end
        // Renames land after writeback so a recycled preg stays not-ready.
        if (!restore) begin
            for (int i = 0; i < NWR; i++) begin
                if (wr_v[i] && wr_a[i] != '0) begin
                    map_preg_d[wr_a[i]] = wr_p[i];
                    map_v_d[wr_a[i]]    = 1'b0;
                end
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (restore) begin
            if (restore_ok) begin
                tail_d  = restore_cp + CW'(1);
                count_d = {1'b0, restore_rel} + (CW+1)'(1);
            end
        end else begin
            if (alloc_ok) tail_d = tail_q + CW'(1);
            if (free_ok)  head_d = head_q + CW'(1);
            count_d = count_q + (CW+1)'(alloc_ok) - (CW+1)'(free_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < AREGS; a++) map_preg_q[a] <= PW'(a);
            map_v_q <= '1;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            map_preg_q <= map_preg_d;
            map_v_q    <= map_v_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state_en) begin
            for (int c = 0; c < NCP; c++) begin
                for (int a = 0; a < AREGS; a++) begin
                    if (wb_hit(ckpt_preg_q[c][a], wb_v, wb_preg)) ckpt_v_q[c][a] <= 1'b1;
                end
            end
            if (alloc_ok) begin
                ckpt_preg_q[tail_q] <= map_preg_d;
                ckpt_v_q[tail_q]    <= map_v_d;
            end
        end
    end

    restore_in_window: assert property (@(posedge clk) disable iff (rst) restore |-> restore_ok);

endmodule

// File: tb/tb_qupls_rename_map.sv
// Bench for qupls_rename_map: directed scenarios with literal expectations, then random traffic
// compared every cycle against an array-based model of the alias table and checkpoint stack.
module tb_qupls_rename_map;

    localparam int AREGS = 64;
    localparam int NRD = 8, NWR = 4, NWB = 4, NCP = 16;
    localparam int AW = 6, PW = 8, CW = 4;

    logic clk = 1'b0;
    logic rst;
    logic [NRD*AW-1:0] rd_areg;
    logic [NRD*PW-1:0] rd_preg;
    logic [NRD-1:0]    rd_v;
    logic [NWR-1:0]    wr_v;
    logic [NWR*AW-1:0] wr_areg;
    logic [NWR*PW-1:0] wr_preg;
    logic [NWR*PW-1:0] wr_old_preg;
    logic [NWB-1:0]    wb_v;
    logic [NWB*PW-1:0] wb_preg;
    logic              cp_alloc, cp_full, cp_free, restore;
    logic [CW-1:0]     cp_id, restore_cp;
    logic [CW:0]       cp_count;

    qupls_rename_map dut (
        .clk(clk), .rst(rst), .rd_areg(rd_areg), .rd_preg(rd_preg), .rd_v(rd_v),
        .wr_v(wr_v), .wr_areg(wr_areg), .wr_preg(wr_preg), .wr_old_preg(wr_old_preg),
        .wb_v(wb_v), .wb_preg(wb_preg), .cp_alloc(cp_alloc), .cp_id(cp_id), .cp_full(cp_full),
        .cp_free(cp_free), .restore(restore), .restore_cp(restore_cp), .cp_count(cp_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    // Reference state: plain arrays and integer pointers.
    int m_map [AREGS];
    bit m_v [AREGS];
    int m_ck [NCP][AREGS];
    bit m_ckv [NCP][AREGS];
    int m_head, m_tail, m_count;
    int nm [AREGS];
    bit nv [AREGS];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int rda(int r); return int'(rd_areg[r*AW +: AW]); endfunction
    function automatic int wra(int i); return int'(wr_areg[i*AW +: AW]); endfunction
    function automatic int wrp(int i); return int'(wr_preg[i*PW +: PW]); endfunction

    function automatic bit wb_hits(int p);
        for (int k = 0; k < NWB; k++) begin
            if (wb_v[k] && int'(wb_preg[k*PW +: PW]) == p) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int exp_rd_preg(int a);
        if (a == 0) return 0;
        for (int w = NWR - 1; w >= 0; w--) if (wr_v[w] && wra(w) == a) return wrp(w);
        return m_map[a];
    endfunction

    function automatic int exp_rd_v(int a);
        if (a == 0) return 1;
        for (int w = 0; w < NWR; w++) if (wr_v[w] && wra(w) == a) return 0;
        return int'(m_v[a]);
    endfunction

    function automatic int exp_old(int i);
        int a;
        a = wra(i);
        if (a != 0) begin
            for (int j = i - 1; j >= 0; j--) if (wr_v[j] && wra(j) == a) return wrp(j);
        end
        return m_map[a];
    endfunction

    always @(posedge clk) begin
        bit al, fr;
        int rc;
        if (rst) begin
            for (int a = 0; a < AREGS; a++) begin
                m_map[a] = a;
                m_v[a]   = 1'b1;
            end
            m_head = 0; m_tail = 0; m_count = 0;
        end else begin
            al = 1'b0; fr = 1'b0;
            if (restore) begin
                rc = int'(restore_cp);
                for (int a = 0; a < AREGS; a++) begin
                    nm[a] = m_ck[rc][a];
                    nv[a] = m_ckv[rc][a];
                end
                m_tail  = (rc + 1) % NCP;
                m_count = (rc - m_head + NCP) % NCP + 1;
            end else begin
                nm = m_map;
                nv = m_v;
            end
            for (int a = 0; a < AREGS; a++) if (wb_hits(nm[a])) nv[a] = 1'b1;
            if (!restore) begin
                for (int i = 0; i < NWR; i++) begin
                    if (wr_v[i] && wra(i) != 0) begin
                        nm[wra(i)] = wrp(i);
                        nv[wra(i)] = 1'b0;
                    end
                end
                fr = cp_free && m_count > 0;
                al = cp_alloc && (m_count < NCP || fr);
            end
            for (int c = 0; c < NCP; c++)
                for (int a = 0; a < AREGS; a++)
                    if (wb_hits(m_ck[c][a])) m_ckv[c][a] = 1'b1;
            if (al) begin
                for (int a = 0; a < AREGS; a++) begin
                    m_ck[m_tail][a]  = nm[a];
                    m_ckv[m_tail][a] = nv[a];
                end
                m_tail = (m_tail + 1) % NCP;
                m_count++;
            end
            if (fr) begin
                m_head = (m_head + 1) % NCP;
                m_count--;
            end
            m_map = nm;
            m_v   = nv;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int r = 0; r < NRD; r++) begin
                check($sformatf("rd_preg[%0d]", r), int'(rd_preg[r*PW +: PW]), exp_rd_preg(rda(r)));
                check($sformatf("rd_v[%0d]", r), int'(rd_v[r]), exp_rd_v(rda(r)));
            end
            for (int i = 0; i < NWR; i++)
                check($sformatf("wr_old_preg[%0d]", i), int'(wr_old_preg[i*PW +: PW]), exp_old(i));
            check("cp_id", int'(cp_id), m_tail);
            check("cp_count", int'(cp_count), m_count);
            check("cp_full", int'(cp_full), int'(m_count == NCP));
        end
    end

    task automatic idle();
        rst = 1'b0; rd_areg = '0; wr_v = '0; wr_areg = '0; wr_preg = '0;
        wb_v = '0; wb_preg = '0; cp_alloc = 1'b0; cp_free = 1'b0;
        restore = 1'b0; restore_cp = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int r, input int a);
        rd_areg[r*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int i, input int a, input int p);
        wr_v[i] = 1'b1;
        wr_areg[i*AW +: AW] = AW'(a);
        wr_preg[i*PW +: PW] = PW'(p);
    endtask

    task automatic set_wb(input int k, input int p);
        wb_v[k] = 1'b1;
        wb_preg[k*PW +: PW] = PW'(p);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        idle();

        // Reset mapping and areg 0
        set_rd(0, 5); set_rd(1, 0); #2;
        check("t1 rd5 preg", int'(rd_preg[0 +: PW]), 5);
        check("t1 rd5 v", int'(rd_v[0]), 1);
        check("t1 rd0 preg", int'(rd_preg[PW +: PW]), 0);
        check("t1 rd0 v", int'(rd_v[1]), 1);
        check("t1 count", int'(cp_count), 0);
        check("t1 full", int'(cp_full), 0);
        check("t1 cp_id", int'(cp_id), 0);

        // Two renames of r3 in one group
        set_wr(0, 3, 100); set_wr(2, 3, 101); set_rd(0, 3); #2;
        check("t2 old2", int'(wr_old_preg[2*PW +: PW]), 100);
        check("t2 old0", int'(wr_old_preg[0 +: PW]), 3);
        check("t2 bypass", int'(rd_preg[0 +: PW]), 101);
        step(); idle(); set_rd(0, 3); #2;
        check("t2 rd3 preg", int'(rd_preg[0 +: PW]), 101);
        check("t2 rd3 v", int'(rd_v[0]), 0);
        set_wb(0, 101); step(); idle(); set_rd(0, 3); #2;
        check("t2 wb v", int'(rd_v[0]), 1);

        // Checkpoint then restore
        set_wr(0, 7, 90); cp_alloc = 1'b1; step(); idle(); #2;
        check("t3 count", int'(cp_count), 1);
        check("t3 cp_id", int'(cp_id), 1);
        set_wr(0, 7, 91); step(); idle(); set_rd(0, 7); #2;
        check("t3 rd7 new", int'(rd_preg[0 +: PW]), 91);
        restore = 1'b1; restore_cp = 0; step(); idle(); set_rd(0, 7); set_rd(1, 3); #2;
        check("t3 rd7 restored", int'(rd_preg[0 +: PW]), 90);
        check("t3 rd7 v", int'(rd_v[0]), 0);
        check("t3 rd3 restored", int'(rd_preg[PW +: PW]), 101);
        check("t3 rd3 v", int'(rd_v[1]), 1);
        check("t3 count after", int'(cp_count), 1);
        check("t3 cp_id after", int'(cp_id), 1);

        // Restore outranks wr/alloc; same-cycle wb lands in restored map
        restore = 1'b1; restore_cp = 0; set_wr(0, 7, 95); cp_alloc = 1'b1; set_wb(0, 90);
        step(); idle(); set_rd(0, 7); #2;
        check("t5 rd7 preg", int'(rd_preg[0 +: PW]), 90);
        check("t5 rd7 v", int'(rd_v[0]), 1);
        check("t5 count", int'(cp_count), 1);
        check("t5 cp_id", int'(cp_id), 1);

        // Fill the stack, overflow, alloc+free at full
        cp_alloc = 1'b1;
        repeat (15) step();
        idle(); #2;
        check("t4 count full", int'(cp_count), 16);
        check("t4 full", int'(cp_full), 1);
        check("t4 cp_id wrap", int'(cp_id), 0);
        cp_alloc = 1'b1; step(); idle(); #2;
        check("t4 17th count", int'(cp_count), 16);
        check("t4 17th cp_id", int'(cp_id), 0);
        cp_alloc = 1'b1; cp_free = 1'b1; step(); idle(); #2;
        check("t4 af count", int'(cp_count), 16);
        check("t4 af cp_id", int'(cp_id), 1);
        restore = 1'b1; restore_cp = 1; step(); idle(); #2;
        check("t4 restore head count", int'(cp_count), 1);
        check("t4 restore head cp_id", int'(cp_id), 2);

        // Reset mid-stream
        set_wr(0, 3, 120); cp_alloc = 1'b1;
        repeat (8) step();
        idle(); #2;
        check("t6 count 9", int'(cp_count), 9);
        rst = 1'b1; step(); idle(); set_rd(0, 3); set_rd(1, 7); #2;
        check("t6 count", int'(cp_count), 0);
        check("t6 cp_id", int'(cp_id), 0);
        check("t6 full", int'(cp_full), 0);
        check("t6 rd3", int'(rd_preg[0 +: PW]), 3);
        check("t6 rd3 v", int'(rd_v[0]), 1);
        check("t6 rd7", int'(rd_preg[PW +: PW]), 7);
        check("t6 rd7 v", int'(rd_v[1]), 1);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            idle();
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
            for (int r = 0; r < NRD; r++)
                set_rd(r, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7));
            for (int i = 0; i < NWR; i++)
                if ($urandom_range(0, 1) == 1)
                    set_wr(i, ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : $urandom_range(1, 63),
                           $urandom_range(1, 255));
            for (int k = 0; k < NWB; k++)
                if ($urandom_range(0, 2) == 0)
                    set_wb(k, ($urandom_range(0, 1) == 1) ? m_map[$urandom_range(1, 63)]
                                                          : $urandom_range(1, 255));
            cp_alloc = ($urandom_range(0, 2) == 0);
            cp_free  = ($urandom_range(0, 3) == 0);
            if (m_count > 0 && $urandom_range(0, 15) == 0) begin
                restore    = 1'b1;
                restore_cp = CW'((m_head + $urandom_range(0, m_count - 1)) % NCP);
            end
            step();
        end
        idle();
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
